// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters with registered syncs and flags.
// Ports: clk_i, rst_ni, pix_en_i, hsync_o, vsync_o, disp_active, xcol_o, yrow_o, frame_start_o. Macro: VGA_SYNC_DELAY_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pix_en_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        disp_active,
  output logic [10:0] xcol_o,
  output logic [10:0] yrow_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_too_big
    $error("vga_sync_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 2048) begin : g_v_too_big
    $error("vga_sync_gen: V_TOTAL exceeds 2048");
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Boundaries kept one bit wider so a 2048 bound still compares correctly.
  localparam logic [11:0] H_ACT_E = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_E = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE    = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic ON  = (SYNC_POL != 0);
  localparam logic OFF = ~ON;

  logic        x_last;
  logic        y_last;
  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic [11:0] x_e;
  logic [11:0] y_e;
  logic        act_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;

  // Flags are computed from the next position so they land in the
  // same cycle as the position they describe.
  always_comb begin
    x_last  = (xcol_o == H_LAST);
    y_last  = (yrow_o == V_LAST);
    x_nxt   = x_last ? 11'd0 : xcol_o + 11'd1;
    y_nxt   = yrow_o;
    if (x_last) begin
      y_nxt = y_last ? 11'd0 : yrow_o + 11'd1;
    end
    x_e     = {1'b0, x_nxt};
    y_e     = {1'b0, y_nxt};
    act_nxt = (x_e < H_ACT_E) && (y_e < V_ACT_E);
    hs_nxt  = ((x_e >= H_SS) && (x_e < H_SE)) ? ON : OFF;
    vs_nxt  = ((y_e >= V_SS) && (y_e < V_SE)) ? ON : OFF;
    fs_nxt  = (x_nxt == 11'd0) && (y_nxt == 11'd0);
  end

  logic hs_q;
  logic vs_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      xcol_o        <= H_LAST;
      yrow_o        <= V_LAST;
      disp_active   <= 1'b0;
      hs_q          <= OFF;
      vs_q          <= OFF;
      frame_start_o <= 1'b0;
    end else if (pix_en_i) begin
      xcol_o        <= x_nxt;
      yrow_o        <= y_nxt;
      disp_active   <= act_nxt;
      hs_q          <= hs_nxt;
      vs_q          <= vs_nxt;
      frame_start_o <= fs_nxt;
    end else begin
      frame_start_o <= 1'b0;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra stage keeps syncs aligned with a registered colour path.
  logic hs_d;
  logic vs_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hs_d <= OFF;
      vs_d <= OFF;
    end else if (pix_en_i) begin
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign hsync_o = hs_d;
  assign vsync_o = vs_d;
`else
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance plus a tiny active-high instance.
// Checks reset, counting, syncs, enable gating, mid-line reset, frames.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int HD = 1;
`else
  localparam int HD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a;
  logic        hs_a, vs_a, act_a, fs_a;
  logic [10:0] x_a, y_a;

  logic        rst_b, en_b;
  logic        hs_b, vs_b, act_b, fs_b;
  logic [10:0] x_b, y_b;

  vga_sync_gen u_a (
    .clk_i(clk), .rst_ni(rst_a), .pix_en_i(en_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .disp_active(act_a),
    .xcol_o(x_a), .yrow_o(y_a), .frame_start_o(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_b), .pix_en_i(en_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .disp_active(act_b),
    .xcol_o(x_b), .yrow_o(y_b), .frame_start_o(fs_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs_cnt, hs_first, act_cnt, act_first, bad;
  int vs_cnt, fs_cnt, fs_at, xmax, ymax;
  logic [10:0] px, py;
  logic pa, ph, pv, pvb;

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    tick(); tick(); tick();
    chk("rst_x", 32'(x_a), 799);
    chk("rst_y", 32'(y_a), 524);
    chk("rst_act", 32'(act_a), 0);
    chk("rst_hs", 32'(hs_a), 1);
    chk("rst_vs", 32'(vs_a), 1);
    chk("rst_fs", 32'(fs_a), 0);

    rst_a = 1'b1;
    tick();
    chk("first_x", 32'(x_a), 0);
    chk("first_y", 32'(y_a), 0);
    chk("first_act", 32'(act_a), 1);
    chk("first_fs", 32'(fs_a), 1);
    tick();
    chk("second_fs", 32'(fs_a), 0);
    chk("second_x", 32'(x_a), 1);

    hs_cnt = 0; hs_first = -1; act_cnt = 0; act_first = -1;
    for (int i = 2; i < 800; i++) begin
      tick();
      if (hs_a == 1'b0) begin
        if (hs_first < 0) hs_first = int'(x_a);
        hs_cnt++;
      end
      if (act_a == 1'b0) begin
        if (act_first < 0) act_first = int'(x_a);
        act_cnt++;
      end
    end
    chk("line_end_x", 32'(x_a), 799);
    chk("hs_width", 32'(hs_cnt), 96);
    chk("hs_first_x", 32'(hs_first), 32'(656 + HD));
    chk("blank_cnt", 32'(act_cnt), 160);
    chk("blank_first_x", 32'(act_first), 640);
    tick();
    chk("wrap_x", 32'(x_a), 0);
    chk("wrap_y", 32'(y_a), 1);
    chk("wrap_act", 32'(act_a), 1);

    bad = 0;
    for (int k = 0; k < 3200; k++) begin
      en_a = ((k % 4) == 3);
      px = x_a; py = y_a; pa = act_a; ph = hs_a; pv = vs_a;
      tick();
      if (!en_a) begin
        if (x_a != px || y_a != py || act_a != pa ||
            hs_a != ph || vs_a != pv || fs_a != 1'b0) bad++;
      end else if (x_a == px) begin
        bad++;
      end
    end
    chk("gate_hold_bad", 32'(bad), 0);
    chk("gate_line_x", 32'(x_a), 0);
    chk("gate_line_y", 32'(y_a), 2);

    en_a = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    chk("mid_x", 32'(x_a), 300);
    chk("mid_y", 32'(y_a), 2);
    rst_a = 1'b0;
    tick();
    chk("mid_rst_x", 32'(x_a), 799);
    chk("mid_rst_y", 32'(y_a), 524);
    chk("mid_rst_act", 32'(act_a), 0);
    chk("mid_rst_hs", 32'(hs_a), 1);
    chk("mid_rst_vs", 32'(vs_a), 1);

    chk("b_rst_x", 32'(x_b), 15);
    chk("b_rst_y", 32'(y_b), 9);
    chk("b_rst_hs", 32'(hs_b), 0);
    chk("b_rst_vs", 32'(vs_b), 0);
    rst_b = 1'b1; en_b = 1'b1;
    tick();
    chk("b_first_x", 32'(x_b), 0);
    chk("b_first_y", 32'(y_b), 0);
    chk("b_first_fs", 32'(fs_b), 1);

    vs_cnt = 0; hs_cnt = 0; act_cnt = 0; fs_cnt = 0; fs_at = -1;
    bad = 0; xmax = 0; ymax = 0; pvb = vs_b;
    for (int i = 1; i <= 160; i++) begin
      tick();
      if (vs_b) vs_cnt++;
      if (hs_b) hs_cnt++;
      if (act_b) act_cnt++;
      if (fs_b) begin fs_cnt++; fs_at = i; end
      if (vs_b != pvb && int'(x_b) != HD) bad++;
      pvb = vs_b;
      if (int'(x_b) > xmax) xmax = int'(x_b);
      if (int'(y_b) > ymax) ymax = int'(y_b);
    end
    chk("b_fs_cnt", 32'(fs_cnt), 1);
    chk("b_fs_period", 32'(fs_at), 160);
    chk("b_vs_cnt", 32'(vs_cnt), 32);
    chk("b_hs_cnt", 32'(hs_cnt), 30);
    chk("b_act_cnt", 32'(act_cnt), 48);
    chk("b_vs_edge_x", 32'(bad), 0);
    chk("b_xmax", 32'(xmax), 15);
    chk("b_ymax", 32'(ymax), 9);
    tick();
    chk("b_fs_clear", 32'(fs_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96: hsync pulse width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter SYNC_POL, default 0: asserted level of hsync_o/vsync_o (0 = active-low).
REQ-010 clk_i  input  1: system clock; the block has a single clock and all logic runs on its rising edge.
REQ-011 rst_ni  input  1: synchronous, active-low reset, sampled on the rising edge of clk_i.
REQ-012 pix_en_i  input  1: pixel-rate enable; the position advances only on clk_i edges where pix_en_i=1.
REQ-013 hsync_o  output  1: horizontal sync, at level SYNC_POL while asserted.
REQ-014 vsync_o  output  1: vertical sync, at level SYNC_POL while asserted.
REQ-015 disp_active  output  1: high when the current position is inside the visible area.
REQ-016 xcol_o  output  11: current column, raw horizontal count 0..H_TOTAL-1.
REQ-017 yrow_o  output  11: current row, raw vertical count 0..V_TOTAL-1.
REQ-018 frame_start_o  output  1: one-clock pulse when the position becomes (0,0).

Function
REQ-019 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-020 H_TOTAL and V_TOTAL SHALL each be <= 2048; a larger value SHALL be a compile-time error.
REQ-021 Every output SHALL be driven directly from a flop; no output has a combinational path from any input.
REQ-022 On a clk_i edge with pix_en_i=1, xcol_o SHALL increment by 1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-023 yrow_o SHALL increment only on the edge where xcol_o wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-024 With pix_en_i=0, all outputs SHALL hold, except frame_start_o, which SHALL be 0.
REQ-025 disp_active SHALL be 1 iff xcol_o<H_ACTIVE and yrow_o<V_ACTIVE, valid in the same cycle as the position it accompanies.
REQ-026 hsync_o SHALL be asserted iff H_ACTIVE+H_FP <= xcol_o < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
REQ-027 vsync_o SHALL be asserted iff V_ACTIVE+V_FP <= yrow_o < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
REQ-028 vsync_o transitions SHALL coincide with xcol_o wrapping to 0.
REQ-029 frame_start_o SHALL be 1 for exactly one clk_i cycle, the cycle in which (xcol_o,yrow_o) first equals (0,0).
REQ-030 Latency from a pix_en_i=1 edge to the updated outputs SHALL be one clk_i cycle.

Reset
REQ-031 While rst_ni=0 at a clk_i edge, the block SHALL load xcol_o=H_TOTAL-1, yrow_o=V_TOTAL-1, disp_active=0, hsync_o=vsync_o=~SYNC_POL and frame_start_o=0; pix_en_i is ignored.
REQ-032 The first pix_en_i=1 edge after rst_ni returns to 1 SHALL produce (0,0), disp_active=1 and frame_start_o=1.
REQ-033 Reset asserted mid-line or mid-frame SHALL take priority over pix_en_i and SHALL apply the values in REQ-031 on that edge.

Configuration
REQ-034 Macro VGA_SYNC_DELAY_EN defined: hsync_o and vsync_o SHALL each be delayed by one extra pix_en_i-qualified stage, so they stay aligned with a downstream colour register.
REQ-035 In that mode, the delay stage SHALL reset to ~SYNC_POL.
REQ-036 Macro VGA_SYNC_DELAY_EN undefined: hsync_o and vsync_o SHALL follow REQ-026 and REQ-027 with no extra delay.
REQ-037 xcol_o, yrow_o, disp_active and frame_start_o SHALL be unaffected by VGA_SYNC_DELAY_EN.

Verification
REQ-038 Reset, then pix_en_i=1 every cycle -> first cycle after reset: xcol_o=0, yrow_o=0, disp_active=1, frame_start_o=1; next cycle: frame_start_o=0.
REQ-039 Count one line at defaults -> hsync_o=0 for exactly 96 enabled cycles, starting at xcol_o=656; disp_active=0 from xcol_o=640 through 799; wrap 799->0 with yrow_o+1.
REQ-040 Run one full frame at defaults -> 420000 enabled cycles between frame_start_o pulses; vsync_o=0 for yrow_o 490..491 only.
REQ-041 pix_en_i asserted 1 cycle in 4 -> outputs change only on enabled edges; line period is 3200 clk_i cycles.
REQ-042 Assert rst_ni=0 at xcol_o=300, yrow_o=200 -> the next edge gives (799,524), disp_active=0, hsync_o=vsync_o=1.
REQ-043 Build with VGA_SYNC_DELAY_EN -> hsync_o falls one enabled cycle after xcol_o=656; disp_active timing is unchanged from the non-delayed build.
